// File: rtl/multicycle_control_fsm_if.sv
// Shared memory port of the multicycle control unit.
// The control unit is the master; memory answers with mem_ready.
interface multicycle_control_fsm_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// RV32I multicycle control unit: fetch/decode/execute/memory/writeback over
// one req/ready memory port, with sticky traps for illegal encodings and timeouts.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    multicycle_control_fsm_if.master mem,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src_b,
    output logic [2:0] imm_sel,
    output logic [3:0] alu_ctrl,
    output logic       instr_retired,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DEC1  = 3'd1,
        S_DEC2  = 3'd2,
        S_EXEC  = 3'd3,
        S_MEM   = 3'd4,
        S_WB    = 3'd5,
        S_TRAP  = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI
    } class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [1:0] CAUSE_ILL = 2'd1;
    localparam logic [1:0] CAUSE_TMO = 2'd2;
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

    state_e               state_q, state_d;
    class_e               cls_q, cls_d;
    logic [3:0]           alu_q, alu_d;
    logic [2:0]           f3_q, f3_d;
    logic [1:0]           cause_q, cause_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    logic       req;
    logic       ready;
    logic       timeout_hit;
    logic       legal;
    class_e     dec_cls;
    logic [3:0] dec_alu;
    logic       taken;

    function automatic logic [3:0] alu_of(logic [2:0] f3, logic alt);
        case (f3)
            3'b000:  alu_of = alt ? 4'd1 : 4'd0;
            3'b001:  alu_of = 4'd5;
            3'b010:  alu_of = 4'd8;
            3'b011:  alu_of = 4'd9;
            3'b100:  alu_of = 4'd4;
            3'b101:  alu_of = alt ? 4'd7 : 4'd6;
            3'b110:  alu_of = 4'd3;
            default: alu_of = 4'd2;
        endcase
    endfunction

    always_comb begin
        legal   = 1'b1;
        dec_cls = C_R;
        dec_alu = 4'd0;
        case (opcode)
            OP_R: begin
                dec_cls = C_R;
                dec_alu = alu_of(funct3, funct7[5]);
                legal   = (funct7 == F7_ZERO) ||
                          (funct7 == F7_ALT &&
                           (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OP_I: begin
                // SUB has no immediate form; only SRAI uses the alternate funct7
                dec_cls = C_I;
                dec_alu = alu_of(funct3, funct3 == 3'b101 && funct7[5]);
                if (funct3 == 3'b001)
                    legal = (funct7 == F7_ZERO);
                else if (funct3 == 3'b101)
                    legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            end
            OP_LOAD: begin
                dec_cls = C_LOAD;
                legal   = !(funct3 == 3'b011 || funct3[2:1] == 2'b11);
            end
            OP_STORE: begin
                dec_cls = C_STORE;
                legal   = (funct3 <= 3'b010);
            end
            OP_BRANCH: begin
                dec_cls = C_BRANCH;
                dec_alu = 4'd1;
                legal   = (funct3[2:1] != 2'b01);
            end
            OP_JAL: dec_cls = C_JAL;
            OP_LUI: begin
                dec_cls = C_LUI;
                dec_alu = 4'd10;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (f3_q)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            3'b110:  taken = alu_ltu;
            default: taken = !alu_ltu;
        endcase
    end

    assign req         = (state_q == S_FETCH) || (state_q == S_MEM);
    assign ready       = req && mem.mem_ready;
    assign timeout_hit = req && !mem.mem_ready && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        alu_d   = alu_q;
        f3_d    = f3_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (ready) begin
                    state_d = S_DEC1;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TMO;
                end
            end
            S_DEC1: state_d = S_DEC2;
            S_DEC2: begin
                if (legal) begin
                    state_d = S_EXEC;
                    cls_d   = dec_cls;
                    alu_d   = dec_alu;
                    f3_d    = funct3;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILL;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_BRANCH:        state_d = S_FETCH;
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (ready) begin
                    state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TMO;
                end
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_TRAP;
        endcase
        // every entry into a memory-access state starts a fresh wait budget
        if (state_d != state_q)
            cnt_d = '0;
        else if (req && !mem.mem_ready)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= C_R;
            alu_q   <= 4'd0;
            f3_q    <= 3'd0;
            cause_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            alu_q   <= alu_d;
            f3_q    <= f3_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    logic req_o, we_o, asel_o;
    logic dp_on;

    always_comb begin
        req_o         = 1'b0;
        we_o          = 1'b0;
        asel_o        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'd0;
        reg_write     = 1'b0;
        wb_sel        = 2'd0;
        alu_src_b     = 1'b0;
        imm_sel       = 3'd0;
        alu_ctrl      = 4'd0;
        instr_retired = 1'b0;
        trap          = 1'b0;
        trap_cause    = 2'd0;
        state_dbg     = 3'd0;
        dp_on         = 1'b0;
        if (rst_n) begin
            state_dbg  = state_q;
            trap_cause = cause_q;
            case (state_q)
                S_FETCH: begin
                    req_o    = 1'b1;
                    ir_write = ready;
                end
                S_EXEC: begin
                    dp_on = 1'b1;
                    if (cls_q == C_BRANCH) begin
                        pc_write      = 1'b1;
                        pc_src        = taken ? 2'd1 : 2'd0;
                        instr_retired = 1'b1;
                    end
                end
                S_MEM: begin
                    dp_on  = 1'b1;
                    req_o  = 1'b1;
                    asel_o = 1'b1;
                    we_o   = (cls_q == C_STORE);
                    if (ready && cls_q == C_STORE) begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                    end
                end
                S_WB: begin
                    dp_on         = 1'b1;
                    reg_write     = 1'b1;
                    pc_write      = 1'b1;
                    instr_retired = 1'b1;
                    wb_sel        = (cls_q == C_LOAD) ? 2'd1 :
                                    (cls_q == C_JAL)  ? 2'd2 : 2'd0;
                    pc_src        = (cls_q == C_JAL)  ? 2'd2 : 2'd0;
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
            if (dp_on) begin
                alu_ctrl = alu_q;
                case (cls_q)
                    C_R:      alu_src_b = 1'b0;
                    C_BRANCH: imm_sel   = 3'd2;
                    C_STORE: begin
                        alu_src_b = 1'b1;
                        imm_sel   = 3'd1;
                    end
                    C_JAL: begin
                        alu_src_b = 1'b1;
                        imm_sel   = 3'd3;
                    end
                    C_LUI: begin
                        alu_src_b = 1'b1;
                        imm_sel   = 3'd4;
                    end
                    default:  alu_src_b = 1'b1;
                endcase
            end
        end
    end

    assign mem.mem_req      = req_o;
    assign mem.mem_we       = we_o;
    assign mem.mem_addr_sel = asel_o;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for the multicycle control unit, checked cycle by cycle
// against an instruction-level model of the expected strobe sequence.
module tb_multicycle_control_fsm;
    localparam int TO = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       asel;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] wbs;
        logic       srcb;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ret;
        logic       trap;
        logic [1:0] cause;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alu_zero, alu_lt, alu_ltu;
    logic       ir_write, pc_write, reg_write, alu_src_b;
    logic       instr_retired, trap;
    logic [1:0] pc_src, wb_sel, trap_cause;
    logic [2:0] imm_sel, state_dbg;
    logic [3:0] alu_ctrl;
    exp_t       obs;

    int n_checks;
    int n_errors;

    multicycle_control_fsm_if mif ();

    multicycle_control_fsm #(
        .MEM_TIMEOUT(TO),
        .TIMEOUT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem(mif.master),
        .opcode(opcode),
        .funct3(funct3),
        .funct7(funct7),
        .alu_zero(alu_zero),
        .alu_lt(alu_lt),
        .alu_ltu(alu_ltu),
        .ir_write(ir_write),
        .pc_write(pc_write),
        .pc_src(pc_src),
        .reg_write(reg_write),
        .wb_sel(wb_sel),
        .alu_src_b(alu_src_b),
        .imm_sel(imm_sel),
        .alu_ctrl(alu_ctrl),
        .instr_retired(instr_retired),
        .trap(trap),
        .trap_cause(trap_cause),
        .state_dbg(state_dbg)
    );

    assign obs = {state_dbg, mif.mem_req, mif.mem_we, mif.mem_addr_sel,
                  ir_write, pc_write, pc_src, reg_write, wb_sel,
                  alu_src_b, imm_sel, alu_ctrl, instr_retired,
                  trap, trap_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input string tag, input exp_t e);
        @(negedge clk);
        chk(tag, 32'(obs), 32'(e));
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(logic [6:0] op, logic [2:0] f3,
                                 logic [6:0] f7);
        case (op)
            OP_R:      return f7 == 7'h00 ||
                              (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            OP_I: begin
                if (f3 == 1) return f7 == 7'h00;
                if (f3 == 5) return f7 == 7'h00 || f7 == 7'h20;
                return 1'b1;
            end
            OP_LOAD:   return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            OP_STORE:  return f3 <= 3'd2;
            OP_BRANCH: return !(f3 inside {3'd2, 3'd3});
            OP_JAL, OP_LUI: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    // ADD SLL SLT SLTU XOR SRL OR AND indexed by funct3
    function automatic exp_t dp_fields(logic [6:0] op, logic [2:0] f3,
                                       logic [6:0] f7);
        exp_t e;
        int base [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
        e = '0;
        case (op)
            OP_R: begin
                e.alu = 4'(base[f3]);
                if (f7 == 7'h20) e.alu = (f3 == 0) ? 4'd1 : 4'd7;
            end
            OP_I: begin
                e.srcb = 1;
                e.alu  = 4'(base[f3]);
                if (f3 == 5 && f7 == 7'h20) e.alu = 4'd7;
            end
            OP_LOAD:  e.srcb = 1;
            OP_STORE: begin e.srcb = 1; e.imm = 3'd1; end
            OP_BRANCH: begin e.imm = 3'd2; e.alu = 4'd1; end
            OP_JAL:   begin e.srcb = 1; e.imm = 3'd3; end
            OP_LUI:   begin e.srcb = 1; e.imm = 3'd4; e.alu = 4'd10; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit br_taken(logic [2:0] f3, logic [31:0] a,
                                    logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            default: return a >= b;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        mif.mem_ready = 1'($urandom);
        cycle("reset", '0);
        rst_n = 1'b1;
    endtask

    task automatic trap_hold(input logic [1:0] cause, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            mif.mem_ready = 1'($urandom);
            opcode = 7'($urandom);
            e = '0;
            e.st = 3'd6;
            e.trap = 1'b1;
            e.cause = cause;
            cycle("trap", e);
        end
        do_reset();
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int flat,
                             input int mlat, input logic [31:0] a,
                             input logic [31:0] b, input int rst_at);
        exp_t e, dp;
        alu_zero = (a == b);
        alu_lt   = ($signed(a) < $signed(b));
        alu_ltu  = (a < b);
        for (int i = 0; i <= flat; i++) begin
            mif.mem_ready = (i == flat);
            e = '0;
            e.req = 1'b1;
            e.irw = (i == flat);
            cycle("fetch", e);
            if (i == TO - 1 && i != flat) begin
                trap_hold(2'd2, 5);
                return;
            end
        end
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        mif.mem_ready = 1'($urandom);
        e = '0;
        e.st = 3'd1;
        cycle("dec1", e);
        mif.mem_ready = 1'($urandom);
        e.st = 3'd2;
        cycle("dec2", e);
        if (!legal(op, f3, f7)) begin
            trap_hold(2'd1, 20);
            return;
        end
        dp = dp_fields(op, f3, f7);
        mif.mem_ready = 1'($urandom);
        e = dp;
        e.st = 3'd3;
        if (op == OP_BRANCH) begin
            e.pcw = 1'b1;
            e.pcs = br_taken(f3, a, b) ? 2'd1 : 2'd0;
            e.ret = 1'b1;
            cycle("exec_br", e);
            return;
        end
        cycle("exec", e);
        if (op == OP_LOAD || op == OP_STORE) begin
            for (int i = 0; i <= mlat; i++) begin
                if (i == rst_at) begin
                    rst_n = 1'b0;
                    mif.mem_ready = 1'($urandom);
                    cycle("mem_rst", '0);
                    rst_n = 1'b1;
                    return;
                end
                mif.mem_ready = (i == mlat);
                e = dp;
                e.st = 3'd4;
                e.req = 1'b1;
                e.asel = 1'b1;
                e.we = (op == OP_STORE);
                if (i == mlat && op == OP_STORE) begin
                    e.pcw = 1'b1;
                    e.ret = 1'b1;
                end
                cycle("mem", e);
                if (i == TO - 1 && i != mlat) begin
                    trap_hold(2'd2, 5);
                    return;
                end
            end
            if (op == OP_STORE) return;
        end
        mif.mem_ready = 1'($urandom);
        e = dp;
        e.st = 3'd5;
        e.rw = 1'b1;
        e.pcw = 1'b1;
        e.ret = 1'b1;
        e.wbs = (op == OP_LOAD) ? 2'd1 : (op == OP_JAL) ? 2'd2 : 2'd0;
        e.pcs = (op == OP_JAL) ? 2'd2 : 2'd0;
        cycle("wb", e);
    endtask

    logic [6:0] ops [7];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        opcode = '0;
        funct3 = '0;
        funct7 = '0;
        alu_zero = 1'b0;
        alu_lt = 1'b0;
        alu_ltu = 1'b0;
        mif.mem_ready = 1'b0;
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI};

        do_reset();
        run_instr(OP_R, 3'd0, 7'h00, 0, 0, 32'd3, 32'd9, -1);
        run_instr(OP_LOAD, 3'd2, 7'h00, 1, 3, 32'd1, 32'd2, -1);
        run_instr(OP_BRANCH, 3'd0, 7'h00, 0, 0, 32'd5, 32'd5, -1);
        run_instr(OP_BRANCH, 3'd1, 7'h00, 0, 0, 32'd5, 32'd5, -1);
        run_instr(7'h7f, 3'd0, 7'h00, 0, 0, 32'd0, 32'd0, -1);
        run_instr(OP_R, 3'd0, 7'h00, 10, 0, 32'd0, 32'd1, -1);
        run_instr(OP_STORE, 3'd2, 7'h00, 0, 3, 32'd0, 32'd1, 2);
        run_instr(OP_STORE, 3'd2, 7'h00, 2, 3, 32'd0, 32'd1, -1);
        run_instr(OP_LOAD, 3'd0, 7'h00, 0, 9, 32'd0, 32'd1, -1);
        run_instr(OP_JAL, 3'd0, 7'h00, 3, 0, 32'd0, 32'd1, -1);
        run_instr(OP_LUI, 3'd0, 7'h00, 0, 0, 32'd0, 32'd1, -1);

        for (int n = 0; n < 300; n++) begin
            logic [6:0]  op;
            logic [2:0]  f3;
            logic [6:0]  f7;
            logic [31:0] a, b;
            int flat, mlat, rat;
            op = ($urandom_range(0, 9) != 0) ? ops[$urandom_range(0, 6)]
                                             : 7'($urandom);
            f3 = 3'($urandom);
            f7 = ($urandom_range(0, 3) != 0)
                 ? (($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00)
                 : 7'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            flat = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 6)
                                                : $urandom_range(0, 3);
            mlat = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 6)
                                                : $urandom_range(0, 3);
            rat = -1;
            if ($urandom_range(0, 11) == 0)
                rat = $urandom_range(0, (mlat < 3) ? mlat : 3);
            run_instr(op, f3, f7, flat, mlat, a, b, rat);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
